// File: rtl/bus_slave_interface.sv
// -----------------------------------------------------------------------------
// bus_slave_interface
//
// Slave end of the 32-bit four-phase system bus. The master raises
// bus_handshake_1 with a command word and the slave answers on
// bus_handshake_2. If the command is addressed to this slave, it performs one
// register access on the local register port. It then returns REPLY_WORDS
// words during the master's read phase. Slaves that are not addressed follow
// the same handshake sequence without driving the bus. This keeps them from
// taking read-phase strobes as new commands.
//
// Command word: [31:28] slave address, [27:24] code (1 = read, 2 = write),
//               [23:16] register index, [15:0] write data.
// Reply word 0: {SLAVE_ADDR, code, index, 8'h00, status}
//               status: 0x00 = ok, 0x01 = bad code, 0x02 = bad index.
// Reply word 1: read data, echoed write data, or 0 on error.
// Reply words 2 and up: 0.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-low reset
//   bus_handshake_1  master strobe
//   bus_handshake_2  slave acknowledge (low whenever this slave is not addressed)
//   bus_data_in      bus data from the master
//   bus_data_out     reply data (zero when not driving)
//   bus_data_oe      output enable for bus_data_out
//   reg_addr         register index (command bits [23:16])
//   reg_wdata        register write data (command bits [15:0])
//   reg_wr           one-cycle register write strobe
//   reg_rdata        register read data, combinational from reg_addr
//   timeout_err      one-cycle stall-timeout pulse (BUS_TIMEOUT_EN builds only)
//
// Build option:
//   BUS_TIMEOUT_EN   when defined, a wait state abandons the transaction after
//                    TIMEOUT_CYCLES stalled cycles and pulses timeout_err.
// -----------------------------------------------------------------------------
module bus_slave_interface #(
    parameter logic [3:0] SLAVE_ADDR     = 4'h1,
    parameter int         NUM_REGS       = 8,
    parameter int         REPLY_WORDS    = 2,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_handshake_1,
    output logic        bus_handshake_2,
    input  logic [31:0] bus_data_in,
    output logic [31:0] bus_data_out,
    output logic        bus_data_oe,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    input  logic [15:0] reg_rdata
`ifdef BUS_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    localparam logic [3:0] CODE_READ  = 4'h1;
    localparam logic [3:0] CODE_WRITE = 4'h2;
    localparam int         IDX_W      = $clog2(REPLY_WORDS);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(REPLY_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_CMD_ACK,
        S_CMD_REL,
        S_RD_WAIT,
        S_RD_DRIVE,
        S_RD_ACK,
        S_RD_REL,
        S_SKIP_LOW,
        S_SKIP_HIGH,
        S_SKIP_END
    } state_t;

    state_t           state;
    logic [31:0]      cmd_reg;
    logic [7:0]       status_reg;
    logic [15:0]      rdata_reg;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] skip_cnt;
    logic [31:0]      reply_data;

    // Status byte for a command addressed to this slave.
    function automatic logic [7:0] status_of(input logic [31:0] cmd);
        if (cmd[27:24] != CODE_READ && cmd[27:24] != CODE_WRITE)
            return 8'h01;
        else if (int'(cmd[23:16]) >= NUM_REGS)
            return 8'h02;
        else
            return 8'h00;
    endfunction

    // The write strobe is decided from the raw bus word as it is latched. This
    // puts reg_wr high during exactly the S_DECODE cycle.
    function automatic logic write_ok(input logic [31:0] cmd);
        return (cmd[31:28] == SLAVE_ADDR) && (cmd[27:24] == CODE_WRITE) &&
               (status_of(cmd) == 8'h00);
    endfunction

    assign reg_addr  = cmd_reg[23:16];
    assign reg_wdata = cmd_reg[15:0];

    // NOTE: every signal assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        reply_data = '0;
        if (word_idx == '0)
            reply_data = {SLAVE_ADDR, cmd_reg[27:24], cmd_reg[23:16], 8'h00, status_reg};
        else if (word_idx == IDX_W'(1) && status_reg == 8'h00)
            reply_data = (cmd_reg[27:24] == CODE_READ) ? {16'h0000, rdata_reg}
                                                       : {16'h0000, cmd_reg[15:0]};
    end

`ifdef BUS_TIMEOUT_EN
    logic        stalled;
    logic        timed_out;
    logic [15:0] stall_cnt;

    // A wait state counts as stalled while the strobe is not at the level that
    // state is waiting for. A stalled cycle never changes state, so clearing
    // the counter whenever the FSM is not stalled also clears it on every
    // state change.
    always_comb begin
        stalled = 1'b0;
        case (state)
            S_CMD_ACK, S_RD_ACK, S_SKIP_LOW, S_SKIP_END: stalled = bus_handshake_1;
            S_RD_WAIT, S_SKIP_HIGH:                      stalled = !bus_handshake_1;
            default:                                     stalled = 1'b0;
        endcase
    end

    assign timed_out = stalled && (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stalled && !timed_out)
            stall_cnt <= stall_cnt + 16'd1;
        else
            stall_cnt <= '0;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the edge, whatever the statement
    // order inside the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            cmd_reg         <= '0;
            status_reg      <= '0;
            rdata_reg       <= '0;
            word_idx        <= '0;
            skip_cnt        <= '0;
            bus_handshake_2 <= 1'b0;
            bus_data_oe     <= 1'b0;
            bus_data_out    <= '0;
            reg_wr          <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            timeout_err     <= 1'b0;
`endif
        end else begin
            reg_wr <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            timeout_err <= 1'b0;
            if (timed_out) begin
                timeout_err     <= 1'b1;
                bus_handshake_2 <= 1'b0;
                bus_data_oe     <= 1'b0;
                bus_data_out    <= '0;
                state           <= S_IDLE;
            end else
`endif
            begin
                case (state)
                    S_IDLE: begin
                        if (bus_handshake_1) begin
                            cmd_reg <= bus_data_in;
                            reg_wr  <= write_ok(bus_data_in);
                            state   <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        if (cmd_reg[31:28] != SLAVE_ADDR) begin
                            state <= S_SKIP_LOW;
                        end else begin
                            // reg_addr has been stable for this whole cycle, so
                            // the read data is valid to capture here.
                            status_reg      <= status_of(cmd_reg);
                            rdata_reg       <= reg_rdata;
                            bus_handshake_2 <= 1'b1;
                            state           <= S_CMD_ACK;
                        end
                    end
                    S_CMD_ACK: begin
                        if (!bus_handshake_1) begin
                            bus_handshake_2 <= 1'b0;
                            state           <= S_CMD_REL;
                        end
                    end
                    S_CMD_REL: begin
                        word_idx <= '0;
                        state    <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        if (bus_handshake_1) begin
                            bus_data_oe  <= 1'b1;
                            bus_data_out <= reply_data;
                            state        <= S_RD_DRIVE;
                        end
                    end
                    S_RD_DRIVE: begin
                        // Data has been on the bus for one cycle before the ack.
                        bus_handshake_2 <= 1'b1;
                        state           <= S_RD_ACK;
                    end
                    S_RD_ACK: begin
                        if (!bus_handshake_1) begin
                            bus_handshake_2 <= 1'b0;
                            bus_data_oe     <= 1'b0;
                            bus_data_out    <= '0;
                            state           <= S_RD_REL;
                        end
                    end
                    S_RD_REL: begin
                        if (word_idx == LAST_WORD) begin
                            state <= S_IDLE;
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                            state    <= S_RD_WAIT;
                        end
                    end
                    S_SKIP_LOW: begin
                        if (!bus_handshake_1) begin
                            skip_cnt <= '0;
                            state    <= S_SKIP_HIGH;
                        end
                    end
                    S_SKIP_HIGH: begin
                        if (bus_handshake_1)
                            state <= S_SKIP_END;
                    end
                    S_SKIP_END: begin
                        if (!bus_handshake_1) begin
                            if (skip_cnt == LAST_WORD) begin
                                state <= S_IDLE;
                            end else begin
                                skip_cnt <= skip_cnt + IDX_W'(1);
                                state    <= S_SKIP_HIGH;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_slave_interface.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_interface
//
// Directed testbench for bus_slave_interface with default parameters
// (SLAVE_ADDR=1, NUM_REGS=8, REPLY_WORDS=2). A small eight-entry register file
// stands in for the peripheral. The master side is driven through a task that
// performs the write phase and then both read-phase handshakes.
// -----------------------------------------------------------------------------
module tb_bus_slave_interface;

    logic        clk;
    logic        reset;
    logic        bus_handshake_1;
    logic        bus_handshake_2;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_data_oe;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic [15:0] reg_rdata;
`ifdef BUS_TIMEOUT_EN
    logic        timeout_err;
`endif

    int passed = 0;
    int total  = 0;

    bus_slave_interface dut (
        .clk             (clk),
        .reset           (reset),
        .bus_handshake_1 (bus_handshake_1),
        .bus_handshake_2 (bus_handshake_2),
        .bus_data_in     (bus_data_in),
        .bus_data_out    (bus_data_out),
        .bus_data_oe     (bus_data_oe),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_wr          (reg_wr),
        .reg_rdata       (reg_rdata)
`ifdef BUS_TIMEOUT_EN
        ,
        .timeout_err     (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral register file: index 0 holds 0x1234 and index 3 holds 0x5A5A.
    logic [15:0] regs [0:7] = '{16'h1234, 16'h0000, 16'h0000, 16'h5A5A,
                                16'h0000, 16'h0000, 16'h0000, 16'h0000};

    assign reg_rdata = (reg_addr < 8'd8) ? regs[reg_addr[2:0]] : 16'hDEAD;

    always @(posedge clk)
        if (reg_wr && reg_addr < 8'd8)
            regs[reg_addr[2:0]] <= reg_wdata;

    // Write-strobe monitor, sampled on the falling edge.
    int          wr_pulses = 0;
    logic [7:0]  last_addr;
    logic [15:0] last_wdata;

    always @(negedge clk)
        if (reg_wr) begin
            wr_pulses  = wr_pulses + 1;
            last_addr  = reg_addr;
            last_wdata = reg_wdata;
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
            passed = passed + 1;
        else
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Wait, bounded, for the acknowledge to reach a level. Then check that it did.
    task automatic wait_hs2(input logic lvl, input string tag);
        int n = 0;
        while (bus_handshake_2 !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus_handshake_2), 32'(lvl));
    endtask

    // One full transaction: command write phase, then two read-phase words.
    task automatic run_txn(input logic [31:0] cmd, output logic [31:0] w0,
                           output logic [31:0] w1);
        logic [31:0] words [2];
        bus_data_in     = cmd;
        bus_handshake_1 = 1'b1;
        wait_hs2(1'b1, "cmd_ack");
        check("cmd_oe", 32'(bus_data_oe), 32'd0);
        bus_handshake_1 = 1'b0;
        bus_data_in     = '0;
        wait_hs2(1'b0, "cmd_rel");
        for (int i = 0; i < 2; i++) begin
            bus_handshake_1 = 1'b1;
            wait_hs2(1'b1, "rd_ack");
            check("rd_oe", 32'(bus_data_oe), 32'd1);
            words[i] = bus_data_out;
            bus_handshake_1 = 1'b0;
            wait_hs2(1'b0, "rd_rel");
            check("rel_oe", 32'(bus_data_oe), 32'd0);
            check("rel_data", bus_data_out, 32'd0);
        end
        w0 = words[0];
        w1 = words[1];
    endtask

    initial begin
        logic [31:0] w0, w1;
        int          wr_before;
        logic        quiet;

        reset           = 1'b0;
        bus_handshake_1 = 1'b0;
        bus_data_in     = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_hs2",  32'(bus_handshake_2), 32'd0);
        check("rst_oe",   32'(bus_data_oe), 32'd0);
        check("rst_data", bus_data_out, 32'd0);
        check("rst_wr",   32'(reg_wr), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Valid write to index 5.
        wr_before = wr_pulses;
        run_txn(32'h1205ABCD, w0, w1);
        check("wr_pulses", 32'(wr_pulses - wr_before), 32'd1);
        check("wr_addr",   32'(last_addr), 32'h05);
        check("wr_wdata",  32'(last_wdata), 32'hABCD);
        check("wr_w0", w0, 32'h12050000);
        check("wr_w1", w1, 32'h0000ABCD);

        // Valid read of index 3, followed by both error cases and a bad-index write.
        wr_before = wr_pulses;
        run_txn(32'h11030000, w0, w1);
        check("rd_w0", w0, 32'h11030000);
        check("rd_w1", w1, 32'h00005A5A);
        run_txn(32'h11090000, w0, w1);
        check("badidx_w0", w0, 32'h11090002);
        check("badidx_w1", w1, 32'h00000000);
        run_txn(32'h17020000, w0, w1);
        check("badcode_w0", w0, 32'h17020001);
        check("badcode_w1", w1, 32'h00000000);
        run_txn(32'h1209FFFF, w0, w1);
        check("badwr_w0", w0, 32'h12090002);
        check("badwr_w1", w1, 32'h00000000);
        check("no_wr_pulses", 32'(wr_pulses - wr_before), 32'd0);

        // Write command to slave 3: three handshake pairs with the bus left idle.
        wr_before = wr_pulses;
        quiet     = 1'b1;
        for (int p = 0; p < 3; p++) begin
            bus_data_in     = (p == 0) ? 32'h3201BEEF : 32'h0;
            bus_handshake_1 = 1'b1;
            repeat (4) begin
                @(negedge clk);
                quiet = quiet & (bus_handshake_2 === 1'b0) & (bus_data_oe === 1'b0);
            end
            bus_handshake_1 = 1'b0;
            bus_data_in     = '0;
            repeat (4) begin
                @(negedge clk);
                quiet = quiet & (bus_handshake_2 === 1'b0) & (bus_data_oe === 1'b0);
            end
        end
        check("skip_quiet", 32'(quiet), 32'd1);
        check("skip_no_wr", 32'(wr_pulses - wr_before), 32'd0);

        // The next command addressed to this slave is answered normally.
        run_txn(32'h11000000, w0, w1);
        check("after_skip_w0", w0, 32'h11000000);
        check("after_skip_w1", w1, 32'h00001234);

        // Read back the register written at the start.
        run_txn(32'h11050000, w0, w1);
        check("readback_w0", w0, 32'h11050000);
        check("readback_w1", w1, 32'h0000ABCD);

        // Reset asserted while the first reply word is acknowledged.
        bus_data_in     = 32'h11030000;
        bus_handshake_1 = 1'b1;
        wait_hs2(1'b1, "pre_rst_cmd_ack");
        bus_handshake_1 = 1'b0;
        bus_data_in     = '0;
        wait_hs2(1'b0, "pre_rst_cmd_rel");
        bus_handshake_1 = 1'b1;
        wait_hs2(1'b1, "pre_rst_rd_ack");
        check("pre_rst_oe", 32'(bus_data_oe), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_hs2",  32'(bus_handshake_2), 32'd0);
        check("async_rst_oe",   32'(bus_data_oe), 32'd0);
        check("async_rst_data", bus_data_out, 32'd0);
        @(negedge clk);
        bus_handshake_1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_txn(32'h11030000, w0, w1);
        check("post_rst_w0", w0, 32'h11030000);
        check("post_rst_w1", w1, 32'h00005A5A);

`ifdef BUS_TIMEOUT_EN
        // The strobe stays high after the command ack until the stall limit expires.
        begin
            int n = 0;
            bus_data_in     = 32'h11000000;
            bus_handshake_1 = 1'b1;
            wait_hs2(1'b1, "to_cmd_ack");
            while (timeout_err !== 1'b1 && n < 1100) begin
                @(negedge clk);
                n++;
            end
            check("to_pulse", 32'(timeout_err), 32'd1);
            check("to_hs2",   32'(bus_handshake_2), 32'd0);
            check("to_oe",    32'(bus_data_oe), 32'd0);
            bus_handshake_1 = 1'b0;
            bus_data_in     = '0;
            @(negedge clk);
            check("to_pulse_end", 32'(timeout_err), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_slave_interface.md
Name: bus_slave_interface

Overview:
- Slave end of the 32-bit system bus driven by the uP interface FSM (bus_handshake_1 / bus_handshake_2 four-phase protocol).
- Captures one command word from the write phase and decodes it.
- If addressed, performs one register access on a local register port, then returns REPLY_WORDS words during the master's read phase.
- One instance per peripheral; non-addressed instances silently track the transaction so they do not treat read-phase handshakes as a new command.

Parameters:
SLAVE_ADDR, 4'h1, bus address matched against command bits [31:28]
NUM_REGS, 8, number of valid register indices (0..NUM_REGS-1)
REPLY_WORDS, 2, words returned per transaction (must be >= 2)
TIMEOUT_CYCLES, 1024, stall limit; used only with BUS_TIMEOUT_EN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
bus_handshake_1  in  1  master strobe
bus_handshake_2  out  1  slave acknowledge (wired-OR across slaves; low when not addressed)
bus_data_in  in  32  bus data from master
bus_data_out  out  32  reply data
bus_data_oe  out  1  output enable for bus_data_out
reg_addr  out  8  register index, equals cmd[23:16]
reg_wdata  out  16  write data, equals cmd[15:0]
reg_wr  out  1  one-cycle write strobe
reg_rdata  in  16  register read data, combinational from reg_addr
timeout_err  out  1  one-cycle pulse; exists only with BUS_TIMEOUT_EN

Behaviour:
- Reset: state S_IDLE. All outputs 0: handshake_2, oe, data_out, reg_wr, timeout_err. cmd_reg=0, word_idx=0.
- Command word fields: [31:28] slave addr; [27:24] code (1=read reg, 2=write reg, others invalid); [23:16] reg index; [15:0] write data.
- S_IDLE: when handshake_1=1, latch bus_data_in into cmd_reg -> S_DECODE.
- S_DECODE:
  - Address mismatch -> S_SKIP_LOW.
  - Address match: status = 0x01 if code invalid; else 0x02 if index >= NUM_REGS; else 0x00.
  - Code 2 with status 0x00: reg_wr=1 for exactly this cycle.
  - -> S_CMD_ACK.
- S_CMD_ACK: handshake_2=1. Capture reg_rdata into rdata_reg on entry cycle. Wait handshake_1=0 -> S_CMD_REL.
- S_CMD_REL: handshake_2=0, word_idx=0 -> S_RD_WAIT.
- S_RD_WAIT: wait handshake_1=1 -> S_RD_DRIVE.
- S_RD_DRIVE: oe=1, data_out=reply[word_idx], handshake_2=0. Data is stable one cycle before ack -> S_RD_ACK.
- S_RD_ACK: oe=1, handshake_2=1, data held. Wait handshake_1=0 -> S_RD_REL.
- S_RD_REL: oe=0, handshake_2=0, data_out=0. If word_idx==REPLY_WORDS-1 -> S_IDLE; else word_idx+1 -> S_RD_WAIT.
- Reply words:
  - word0 = {SLAVE_ADDR, code, index, 8'h00, status}.
  - word1 = {16'h0, rdata_reg} for read; {16'h0, cmd[15:0]} for write; 0 on error.
  - Words 2+ = 0.
- Skip path, never drives bus:
  - S_SKIP_LOW: wait handshake_1=0 (end of write phase). skip_cnt=0 -> S_SKIP_HIGH.
  - S_SKIP_HIGH: wait handshake_1=1 -> S_SKIP_END.
  - S_SKIP_END: wait handshake_1=0. If skip_cnt==REPLY_WORDS-1 -> S_IDLE; else skip_cnt+1 -> S_SKIP_HIGH.
- handshake_1 already low on entry to a wait-for-low state: transition next cycle. No zero-cycle skipping.
- Asynchronous reset mid-transaction: immediately releases handshake_2 and oe, returns to S_IDLE. Any half-finished master transaction is abandoned.
- Only one reg_wr per transaction; reg_wr never asserted for a non-addressed slave.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - 16-bit stall counter clears on every state change and increments in every wait state except S_IDLE.
  - When it reaches TIMEOUT_CYCLES-1: pulse timeout_err one cycle; force handshake_2=0, oe=0; go to S_IDLE.
- BUS_TIMEOUT_EN undefined: no counter, no timeout_err port; wait states wait forever.

Test Plan:
- Write 0x1205ABCD, SLAVE_ADDR=1 -> reg_wr one cycle, reg_addr=0x05, reg_wdata=0xABCD. Replies 0x12050000, 0x0000ABCD.
- Read 0x11030000 with reg_rdata=0x5A5A -> no reg_wr. Replies 0x11030000, 0x00005A5A. oe high only in DRIVE/ACK.
- Read index 0x09 (NUM_REGS=8) -> status 0x02, word1=0. Code 0x7 -> status 0x01. No reg_wr in either case.
- Command addressed to slave 0x3 -> handshake_2 and oe stay 0 through all 3 handshake pairs. Next command 0x11000000 is answered normally.
- Assert reset during S_RD_ACK -> handshake_2=0 and oe=0 asynchronously. Following transaction completes correctly.
- With BUS_TIMEOUT_EN: hold handshake_1 high after command ack for TIMEOUT_CYCLES -> timeout_err pulse, handshake_2=0, state S_IDLE.
